// File: rtl/service_arbiter_pkg.sv
// Shared codes and state encoding for the service arbiter and the blocks around it.
package service_arbiter_pkg;

  localparam int unsigned N_SVC  = 4;
  localparam int unsigned PUSH_W = 5;
  localparam int unsigned NUM_W  = 16;

  localparam logic [NUM_W-1:0] BLANK_NUM = 16'hFFFF;

  localparam logic [N_SVC-1:0] SERVICE1     = 4'b1000;
  localparam logic [N_SVC-1:0] SERVICE2     = 4'b0100;
  localparam logic [N_SVC-1:0] SERVICE3     = 4'b0010;
  localparam logic [N_SVC-1:0] SERVICE4     = 4'b0001;
  localparam logic [N_SVC-1:0] SERVICERESET = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_DONE  = 3'd2,
    ST_ERR   = 3'd3,
    ST_ALARM = 3'd4
  } state_e;

  // True when the switch word selects exactly one service.
  function automatic logic is_service(input logic [N_SVC-1:0] sw);
    case (sw)
      SERVICE1, SERVICE2, SERVICE3, SERVICE4: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for one raw button followed by a registered rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      meta   <= d;
      sync   <= meta;
      sync_d <= sync;
      pulse  <= sync & ~sync_d;
    end
  end

endmodule

// File: rtl/service_arbiter.sv
// Grants the shared buttons/display/LEDs to one service chosen by the mode switches;
// an alarm match preempts everything and hands the I/O to service 4.
module service_arbiter
  import service_arbiter_pkg::*;
(
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [N_SVC-1:0]         spdt_service,
  input  logic [PUSH_W-1:0]        push,
  input  logic                     alarm_hit,
  input  logic [N_SVC-1:0]         finish,
  input  logic [NUM_W-1:0]         cur_time,
  input  logic [N_SVC*NUM_W-1:0]   svc_num,
  input  logic [N_SVC*N_SVC-1:0]   svc_sel,
  output logic [N_SVC-1:0]         grant,
  output logic [N_SVC*PUSH_W-1:0]  push_svc,
  output logic [NUM_W-1:0]         disp_num,
  output logic [N_SVC-1:0]         disp_sel,
  output logic [N_SVC-1:0]         spdt_led,
  output logic                     error
);

  logic [N_SVC-1:0]  sw_meta;
  logic [N_SVC-1:0]  sw_sync;
  logic [PUSH_W-1:0] push_pulse;

  state_e            state_q;
  state_e            state_d;
  logic [N_SVC-1:0]  owner_q;
  logic [N_SVC-1:0]  owner_d;

  // Mode switches only need a level synchronizer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= spdt_service;
      sw_sync <= sw_meta;
    end
  end

  for (genvar b = 0; b < PUSH_W; b++) begin : g_push
    sync_edge u_sync_edge (
      .clk    (clk),
      .resetn (resetn),
      .d      (push[b]),
      .pulse  (push_pulse[b])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      owner_q <= SERVICERESET;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    grant    = '0;
    error    = 1'b0;
    disp_num = cur_time;
    disp_sel = '0;
    push_svc = '0;

    // Alarm outranks every other transition, including a same-cycle finish.
    if (alarm_hit && (state_q != ST_ALARM)) begin
      state_d = ST_ALARM;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sw_sync != SERVICERESET) begin
            if (is_service(sw_sync)) begin
              state_d = ST_GRANT;
              owner_d = sw_sync;
            end else begin
              state_d = ST_ERR;
            end
          end
        end
        ST_GRANT: begin
          if ((finish & owner_q) != SERVICERESET) begin
            state_d = ST_DONE;
          end else if (sw_sync == SERVICERESET) begin
            state_d = ST_IDLE;
          end else if (sw_sync != owner_q) begin
            state_d = ST_ERR;
          end
        end
        ST_DONE, ST_ERR: begin
          if (sw_sync == SERVICERESET) begin
            state_d = ST_IDLE;
          end
        end
        ST_ALARM: begin
          if (finish[0]) begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    case (state_q)
      ST_GRANT: grant = owner_q;
      ST_ALARM: grant = SERVICE4;
      ST_ERR: begin
        error    = 1'b1;
        disp_num = BLANK_NUM;
      end
      default: ;
    endcase

    // Route display slice, blink select and press pulses from/to the single owner.
    for (int unsigned i = 0; i < N_SVC; i++) begin
      if (grant[i]) begin
        disp_num                     = svc_num[i*NUM_W +: NUM_W];
        disp_sel                     = svc_sel[i*N_SVC +: N_SVC];
        push_svc[i*PUSH_W +: PUSH_W] = push_pulse;
      end
    end
  end

  assign spdt_led = grant;

endmodule

// File: tb/tb_service_arbiter.sv
// Directed scenarios plus randomized traffic checked against a service-level reference model.
module tb_service_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  spdt_service;
  logic [4:0]  push;
  logic        alarm_hit;
  logic [3:0]  finish;
  logic [15:0] cur_time;
  logic [63:0] svc_num;
  logic [15:0] svc_sel;
  logic [3:0]  grant;
  logic [19:0] push_svc;
  logic [15:0] disp_num;
  logic [3:0]  disp_sel;
  logic [3:0]  spdt_led;
  logic        error;

  service_arbiter dut (
    .clk          (clk),
    .resetn       (resetn),
    .spdt_service (spdt_service),
    .push         (push),
    .alarm_hit    (alarm_hit),
    .finish       (finish),
    .cur_time     (cur_time),
    .svc_num      (svc_num),
    .svc_sel      (svc_sel),
    .grant        (grant),
    .push_svc     (push_svc),
    .disp_num     (disp_num),
    .disp_sel     (disp_sel),
    .spdt_led     (spdt_led),
    .error        (error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  localparam int MD_IDLE  = 0;
  localparam int MD_GRANT = 1;
  localparam int MD_DONE  = 2;
  localparam int MD_ERR   = 3;
  localparam int MD_ALARM = 4;

  // Reference model: mode, owning service number (1..4), and input histories per clock edge.
  int         m_mode;
  int         m_svc;
  logic [3:0] sw_h0, sw_h1;
  logic [4:0] p_h0, p_h1, p_h2;
  logic [4:0] m_pulse;

  function automatic int svc_of(input logic [3:0] s);
    case (s)
      4'b1000: return 1;
      4'b0100: return 2;
      4'b0010: return 3;
      4'b0001: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode  = MD_IDLE;
    m_svc   = 0;
    sw_h0   = '0;
    sw_h1   = '0;
    p_h0    = '0;
    p_h1    = '0;
    p_h2    = '0;
    m_pulse = '0;
  endtask

  // Switches are seen two edges late; a press pulse marks a 0->1 of the button two edges back.
  task automatic model_edge();
    logic [3:0] s;
    if (!resetn) begin
      model_reset();
      return;
    end
    s = sw_h1;
    if (alarm_hit && m_mode != MD_ALARM) begin
      m_mode = MD_ALARM;
    end else begin
      case (m_mode)
        MD_IDLE:
          if (s != 4'b0000) begin
            if (svc_of(s) != 0) begin
              m_mode = MD_GRANT;
              m_svc  = svc_of(s);
            end else begin
              m_mode = MD_ERR;
            end
          end
        MD_GRANT:
          if (finish[4-m_svc])            m_mode = MD_DONE;
          else if (s == 4'b0000)          m_mode = MD_IDLE;
          else if (svc_of(s) != m_svc)    m_mode = MD_ERR;
        MD_DONE, MD_ERR:
          if (s == 4'b0000)               m_mode = MD_IDLE;
        default:
          if (finish[0])                  m_mode = MD_DONE;
      endcase
    end
    m_pulse = p_h1 & ~p_h2;
    sw_h1   = sw_h0;
    sw_h0   = spdt_service;
    p_h2    = p_h1;
    p_h1    = p_h0;
    p_h0    = push;
  endtask

  function automatic int owner_num();
    if (m_mode == MD_GRANT) return m_svc;
    if (m_mode == MD_ALARM) return 4;
    return 0;
  endfunction

  function automatic logic [3:0] exp_grant();
    logic [3:0] g;
    g = '0;
    if (owner_num() != 0) g[4-owner_num()] = 1'b1;
    return g;
  endfunction

  function automatic logic [19:0] exp_push();
    logic [19:0] e;
    e = '0;
    if (owner_num() != 0) e[(4-owner_num())*5 +: 5] = m_pulse;
    return e;
  endfunction

  function automatic logic [15:0] exp_disp();
    if (m_mode == MD_ERR)   return 16'hFFFF;
    if (owner_num() != 0)   return svc_num[(4-owner_num())*16 +: 16];
    return cur_time;
  endfunction

  function automatic logic [3:0] exp_sel();
    if (owner_num() != 0) return svc_sel[(4-owner_num())*4 +: 4];
    return 4'b0000;
  endfunction

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    resetn       = 1'b0;
    spdt_service = '0;
    push         = '0;
    alarm_hit    = 1'b0;
    finish       = '0;
    cur_time     = 16'h1234;
    svc_num      = {$urandom, $urandom};
    svc_sel      = 16'($urandom);
    model_reset();
    step(3);
    total++; if (grant !== 4'b0000)   begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
    total++; if (push_svc !== 20'h0)  begin bad++; $display("FAIL reset_push got=%h want=0", push_svc); end
    total++; if (disp_num !== 16'h1234) begin bad++; $display("FAIL reset_disp got=%h want=1234", disp_num); end
    total++; if ({spdt_led, disp_sel, error} !== 9'b0) begin bad++; $display("FAIL reset_misc got=%b want=0", {spdt_led, disp_sel, error}); end
    resetn = 1'b1;
    step(2);
  endtask

  task automatic test_grant_press();
    spdt_service = 4'b1000;
    step(2);
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL grant_early got=%b want=0000", grant); end
    step(1);
    total++; if (grant !== 4'b1000)    begin bad++; $display("FAIL grant_svc1 got=%b want=1000", grant); end
    total++; if (spdt_led !== 4'b1000) begin bad++; $display("FAIL led_svc1 got=%b want=1000", spdt_led); end
    total++; if (disp_num !== svc_num[63:48]) begin bad++; $display("FAIL disp_svc1 got=%h want=%h", disp_num, svc_num[63:48]); end
    push = 5'b00001;
    step(2);
    total++; if (push_svc !== 20'h0) begin bad++; $display("FAIL press_early got=%h want=0", push_svc); end
    step(1);
    total++; if (push_svc !== 20'h08000) begin bad++; $display("FAIL press_pulse got=%h want=08000", push_svc); end
    step(1);
    total++; if (push_svc !== 20'h0) begin bad++; $display("FAIL press_width got=%h want=0", push_svc); end
    push = '0;
    spdt_service = 4'b0000;
    step(3);
  endtask

  task automatic test_finish();
    spdt_service = 4'b0100;
    step(3);
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL svc2_grant got=%b want=0100", grant); end
    finish = 4'b0100;
    step(1);
    finish = 4'b0000;
    total++; if (grant !== 4'b0000 || disp_num !== cur_time) begin bad++; $display("FAIL done got=%b/%h want=0000/%h", grant, disp_num, cur_time); end
    step(6);
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL done_hold got=%b want=0000", grant); end
    spdt_service = 4'b0000;
    step(3);
    spdt_service = 4'b0100;
    step(3);
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL rearm got=%b want=0100", grant); end
    spdt_service = 4'b0000;
    step(3);
  endtask

  task automatic test_error();
    spdt_service = 4'b1010;
    step(3);
    total++; if (error !== 1'b1 || disp_num !== 16'hFFFF || grant !== 4'b0000) begin bad++; $display("FAIL err got=%b/%h/%b want=1/ffff/0000", error, disp_num, grant); end
    spdt_service = 4'b0000;
    step(3);
    total++; if (error !== 1'b0 || disp_num !== cur_time) begin bad++; $display("FAIL err_clear got=%b/%h want=0/%h", error, disp_num, cur_time); end
  endtask

  task automatic test_alarm();
    spdt_service = 4'b0010;
    step(3);
    alarm_hit = 1'b1;
    finish    = 4'b0010;
    step(1);
    alarm_hit = 1'b0;
    finish    = 4'b0000;
    total++; if (grant !== 4'b0001 || disp_num !== svc_num[15:0]) begin bad++; $display("FAIL alarm got=%b/%h want=0001/%h", grant, disp_num, svc_num[15:0]); end
    step(2);
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL alarm_hold got=%b want=0001", grant); end
    finish = 4'b0001;
    step(1);
    finish = 4'b0000;
    step(3);
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL alarm_done got=%b want=0000", grant); end
    spdt_service = 4'b0000;
    step(3);
  endtask

  task automatic test_hold_button();
    int pulses;
    int stray;
    spdt_service = 4'b0010;
    step(3);
    push   = 5'b10000;
    pulses = 0;
    stray  = 0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      if (push_svc[9]) pulses++;
      if ((push_svc & ~20'h00200) != 20'h0) stray++;
    end
    total++; if (pulses != 1 || stray != 0) begin bad++; $display("FAIL hold_pulses got=%0d/%0d want=1/0", pulses, stray); end
    push = '0;
    spdt_service = 4'b0000;
    step(4);
    push  = 5'b11111;
    stray = 0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (push_svc != 20'h0) stray++;
    end
    total++; if (stray != 0) begin bad++; $display("FAIL idle_press got=%0d want=0", stray); end
    push = '0;
    step(3);
  endtask

  task automatic test_reset_mid();
    spdt_service = 4'b1000;
    step(3);
    push = 5'b00001;
    step(3);
    total++; if (push_svc !== 20'h08000) begin bad++; $display("FAIL mid_pulse got=%h want=08000", push_svc); end
    resetn = 1'b0;
    #1;
    model_reset();
    total++; if (grant !== 4'b0000 || push_svc !== 20'h0 || spdt_led !== 4'b0000) begin bad++; $display("FAIL mid_reset got=%b/%h/%b want=0", grant, push_svc, spdt_led); end
    @(negedge clk);
    spdt_service = 4'b0000;
    step(2);
    resetn = 1'b1;
    step(5);
    total++; if (grant !== 4'b0000 || push_svc !== 20'h0 || error !== 1'b0) begin bad++; $display("FAIL post_reset got=%b/%h/%b want=idle", grant, push_svc, error); end
    push = '0;
    step(3);
  endtask

  task automatic test_random();
    logic [3:0] sw_pick [6];
    sw_pick[0] = 4'b0000; sw_pick[1] = 4'b1000; sw_pick[2] = 4'b0100;
    sw_pick[3] = 4'b0010; sw_pick[4] = 4'b0001; sw_pick[5] = 4'b0110;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 11) == 0) spdt_service = sw_pick[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0)  push = 5'($urandom);
      alarm_hit = ($urandom_range(0, 59) == 0);
      finish    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 7) == 0) begin
        cur_time = 16'($urandom);
        svc_num  = {$urandom, $urandom};
        svc_sel  = 16'($urandom);
      end
      step(1);
      total++; if (grant !== exp_grant())   begin bad++; $display("FAIL rnd_grant cyc=%0d got=%b want=%b", k, grant, exp_grant()); end
      total++; if (push_svc !== exp_push()) begin bad++; $display("FAIL rnd_push cyc=%0d got=%h want=%h", k, push_svc, exp_push()); end
      total++; if (disp_num !== exp_disp()) begin bad++; $display("FAIL rnd_disp cyc=%0d got=%h want=%h", k, disp_num, exp_disp()); end
      total++; if (disp_sel !== exp_sel())  begin bad++; $display("FAIL rnd_sel cyc=%0d got=%b want=%b", k, disp_sel, exp_sel()); end
      total++; if (spdt_led !== exp_grant()) begin bad++; $display("FAIL rnd_led cyc=%0d got=%b want=%b", k, spdt_led, exp_grant()); end
      total++; if (error !== (m_mode == MD_ERR)) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b want=%b", k, error, (m_mode == MD_ERR)); end
    end
  endtask

  initial begin
    test_reset();
    test_grant_press();
    test_finish();
    test_error();
    test_alarm();
    test_hold_button();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
